// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file dump block.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } dump_state_e;

    // Next register index, wrapping after the highest implemented register.
    function automatic logic [REG_ADDR_W-1:0] nextIdx(
        input logic [REG_ADDR_W-1:0] idx,
        input int                    nregs
    );
        if (int'(idx) == nregs - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: one write port, one combinational read port.
// Register x0 always reads as zero and ignores writes.
module regfile #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] wa,
    input  logic [XLEN-1:0]                    wd,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] ra1,
    output logic [XLEN-1:0]                    rd1
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Writes land on the rising edge; x0 is never written.
    always_ff @(posedge clk) begin
        if (we && (wa != '0)) begin
            mem_q[wa] <= wd;
        end
    end

    // Combinational read with x0 hard-wired to zero.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = mem_q[ra1];
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Walks a contiguous (possibly wrapping) range of register indices, reads each
// register through the register-file read port and presents it on a
// valid/ready output stream, pulsing done once the last word is accepted.
module regfile_dump #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] first,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] last,
    output logic [regfile_pkg::REG_ADDR_W-1:0] ra,
    input  logic [XLEN-1:0]                    rd,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [regfile_pkg::REG_ADDR_W-1:0] out_addr,
    output logic [XLEN-1:0]                    out_data,
    output logic                               busy,
    output logic                               done
);

    import regfile_pkg::*;

    dump_state_e             state_q;
    logic [REG_ADDR_W-1:0]   idx_q;
    logic [REG_ADDR_W-1:0]   stop_q;
    logic [REG_ADDR_W-1:0]   outAddr_q;
    logic [XLEN-1:0]         outData_q;
    logic                    outValid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [REG_ADDR_W-1:0]   idxInc_d;

    // Candidate next index, wrapping from the top register back to x0.
    always_comb begin
        idxInc_d = nextIdx(idx_q, NREGS);
    end

    // Dump sequencer: captures the range on start, then alternates between
    // sampling a register (READ) and waiting for the consumer (HOLD).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stop_q     <= '0;
            outAddr_q  <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= first;
                        stop_q  <= last;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    outData_q  <= rd;
                    outAddr_q  <= idx_q;
                    outValid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        if (idx_q == stop_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idxInc_d;
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The read address only points at a register while a dump is running.
    always_comb begin
        ra = '0;
        if ((state_q == READ) || (state_q == HOLD)) begin
            ra = idx_q;
        end
    end

    assign out_valid = outValid_q;
    assign out_addr  = outAddr_q;
    assign out_data  = outData_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
